spi_fetch_arbiter: RTL and testbench

Two-port arbiter and sequencer sharing the single-byte SPI RAM reader (`spi_read_byte`) between an instruction-fetch requester (port 0) and a data-load requester (port 1). It accepts burst requests of 1–4 consecutive bytes and issues one SPI byte read per byte. Read data returns to the granted port with per-byte valid and last strobes. It sits between the CPU fetch/execute logic and the SPI reader, which it drives directly.

---
 rtl/spi_fetch_arbiter_if.sv | 32 +++
 rtl/spi_fetch_arbiter.sv | 117 +++++++++++
 tb/tb_spi_fetch_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fetch_arbiter_if.sv
// Bus bundle between the fetch/load requesters, the fetch arbiter and the SPI byte reader.
// The slave modport is the arbiter's view; master is the requester/reader environment.
interface spi_fetch_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 2
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [7:0]        rdata;
  logic              rlast;
  logic              busy;
  logic              spi_start;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_busy;
  logic              spi_done;
  logic [7:0]        spi_data;

  modport slave (
    input  req, addr0, addr1, len0, len1, spi_busy, spi_done, spi_data,
    output gnt, rvalid, rdata, rlast, busy, spi_start, spi_addr
  );

  modport master (
    output req, addr0, addr1, len0, len1, spi_busy, spi_done, spi_data,
    input  gnt, rvalid, rdata, rlast, busy, spi_start, spi_addr
  );
endinterface

// File: rtl/spi_fetch_arbiter.sv
// Round-robin arbiter sharing one SPI byte reader between instruction fetch (port 0) and
// data load (port 1); each grant runs a 1..4 byte burst, one SPI read per byte.
module spi_fetch_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 2
) (
  input logic               clk,
  input logic               reset,
  spi_fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              last_gnt_q, last_gnt_d;
  logic              winner;

  // On a tie, serve the port that was not served last.
  always_comb begin
    winner = bus.req[0] ? 1'b0 : 1'b1;
    if (bus.req == 2'b11) winner = ~last_gnt_q;
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    gnt_d       = gnt_q;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    rlast_d     = 1'b0;
    busy_d      = busy_q;
    start_d     = 1'b0;
    last_gnt_d  = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d     = StIssue;
          busy_d      = 1'b1;
          gnt_d       = winner ? 2'b10 : 2'b01;
          cur_addr_d  = winner ? bus.addr1 : bus.addr0;
          remaining_d = winner ? bus.len1 : bus.len0;
        end
      end
      StIssue: begin
        if (!bus.spi_busy) begin
          start_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.spi_done) begin
          rdata_d  = bus.spi_data;
          rvalid_d = gnt_q;
          if (remaining_q == '0) begin
            rlast_d = 1'b1;
            state_d = StDone;
          end else begin
            cur_addr_d  = cur_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StDone: begin
        gnt_d      = 2'b00;
        last_gnt_d = gnt_q[1];
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= 8'h00;
      rlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rlast_q     <= rlast_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.rlast     = rlast_q;
  assign bus.busy      = busy_q;
  assign bus.spi_start = start_q;
  assign bus.spi_addr  = cur_addr_q;

endmodule

// File: tb/tb_spi_fetch_arbiter.sv
// Directed bench for spi_fetch_arbiter: behavioural SPI reader model, negedge monitor,
// and one task per scenario with hand-computed expectations.
module tb_spi_fetch_arbiter;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 2;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_fetch_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
  spi_fetch_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // SPI reader model: busy for LAT cycles after a start, then a one-cycle done pulse.
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic [7:0]        m_data = 8'h00;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_cnt = 0;
  logic              bp_busy = 1'b0;
  logic              stray_done = 1'b0;
  logic [7:0]        stray_data = 8'h00;

  assign bus.spi_busy = m_busy | bp_busy;
  assign bus.spi_done = m_done | stray_done;
  assign bus.spi_data = stray_done ? stray_data : m_data;

  function automatic logic [7:0] spi_byte(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0010: return 8'hA5;
      16'h0020: return 8'h11;
      16'h0021: return 8'h12;
      16'h0022: return 8'h13;
      16'h0023: return 8'h14;
      default:  return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.spi_start) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
        m_addr <= bus.spi_addr;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_data <= spi_byte(m_addr);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Monitor: records starts, returned bytes and grant rises.
  logic [ADDR_W-1:0] start_q[$];
  logic [7:0]        rv_q[$];
  logic [1:0]        rvp_q[$];
  logic              rl_q[$];
  logic [1:0]        gseq_q[$];
  int                twohot = 0;
  int                start_busy = 0;
  logic [1:0]        prev_gnt = 2'b00;

  always @(negedge clk) begin
    if (bus.spi_start) start_q.push_back(bus.spi_addr);
    if (bus.spi_start && bus.spi_busy) start_busy++;
    if (bus.rvalid != 2'b00) begin
      rv_q.push_back(bus.rdata);
      rvp_q.push_back(bus.rvalid);
      rl_q.push_back(bus.rlast);
    end
    if ($countones(bus.gnt) > 1) twohot++;
    if (prev_gnt == 2'b00 && bus.gnt != 2'b00) gseq_q.push_back(bus.gnt);
    prev_gnt = bus.gnt;
  end

  task automatic clear_mon();
    start_q.delete();
    rv_q.delete();
    rvp_q.delete();
    rl_q.delete();
    gseq_q.delete();
    twohot = 0;
    start_busy = 0;
  endtask

  // Requester: raise req, hold until rlast is seen, drop it on the sampling edge.
  task automatic do_burst(input int p, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (p == 0) begin bus.addr0 = a; bus.len0 = l; end
    else begin bus.addr1 = a; bus.len1 = l; end
    bus.req[p] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.rlast) ok = 1'b1;
    end
    @(posedge clk);
    #1 bus.req[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++;
      $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++;
      $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); end
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++;
      $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    vectors++; if (bus.rlast !== 1'b0) begin miscompares++;
      $display("FAIL reset_rlast: got %b want 0", bus.rlast); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.spi_start !== 1'b0) begin miscompares++;
      $display("FAIL reset_start: got %b want 0", bus.spi_start); end
    vectors++; if (bus.spi_addr !== 16'h0000) begin miscompares++;
      $display("FAIL reset_spi_addr: got %h want 0000", bus.spi_addr); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin miscompares++;
      $display("FAIL idle_no_req: got busy=%b gnt=%b want 0/00", bus.busy, bus.gnt); end
  endtask

  task automatic test_single();
    bit got;
    clear_mon();
    bus.addr0 = 16'h0010; bus.len0 = 2'd0; bus.req[0] = 1'b1;
    @(negedge clk);
    vectors++; if (bus.gnt !== 2'b01 || bus.busy !== 1'b1 || bus.spi_start !== 1'b0) begin
      miscompares++; $display("FAIL single_grant: got gnt=%b busy=%b start=%b want 01/1/0",
                              bus.gnt, bus.busy, bus.spi_start); end
    @(negedge clk);
    vectors++; if (bus.spi_start !== 1'b1 || bus.spi_addr !== 16'h0010) begin miscompares++;
      $display("FAIL single_start: got start=%b addr=%h want 1/0010", bus.spi_start,
               bus.spi_addr); end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.rlast;
    end
    vectors++; if (got !== 1'b1) begin miscompares++;
      $display("FAIL single_timeout: got rlast=%b want 1", got); end
    vectors++; if (bus.rvalid !== 2'b01 || bus.rdata !== 8'hA5) begin miscompares++;
      $display("FAIL single_data: got rvalid=%b rdata=%h want 01/a5", bus.rvalid, bus.rdata); end
    @(posedge clk);
    #1 bus.req[0] = 1'b0;
    @(negedge clk);
    vectors++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL single_release: got gnt=%b busy=%b want 00/0", bus.gnt, bus.busy); end
    vectors++; if (start_q.size() != 1) begin miscompares++;
      $display("FAIL single_nstart: got %0d want 1", start_q.size()); end
  endtask

  task automatic test_burst();
    bit ok;
    logic [ADDR_W-1:0] ea;
    logic [7:0] ed;
    clear_mon();
    do_burst(1, 16'h0020, 2'd3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL burst_timeout: got 0 want 1"); end
    vectors++; if (start_q.size() != 4 || rv_q.size() != 4) begin miscompares++;
      $display("FAIL burst_count: got starts=%0d bytes=%0d want 4/4", start_q.size(),
               rv_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        ea = 16'h0020 + 16'(i);
        ed = 8'h11 + 8'(i);
        vectors++; if (start_q[i] !== ea) begin miscompares++;
          $display("FAIL burst_addr%0d: got %h want %h", i, start_q[i], ea); end
        vectors++; if (rv_q[i] !== ed || rvp_q[i] !== 2'b10) begin miscompares++;
          $display("FAIL burst_data%0d: got %h/%b want %h/10", i, rv_q[i], rvp_q[i], ed); end
        vectors++; if (rl_q[i] !== (i == 3)) begin miscompares++;
          $display("FAIL burst_rlast%0d: got %b want %b", i, rl_q[i], (i == 3)); end
      end
    end
  endtask

  task automatic test_contention();
    int n;
    int p;
    logic [1:0] eg;
    reset = 1'b1;
    bus.addr0 = 16'h0040; bus.len0 = 2'd0;
    bus.addr1 = 16'h0080; bus.len1 = 2'd1;
    bus.req = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (bus.rlast) begin
        p = bus.rvalid[1] ? 1 : 0;
        n++;
        @(posedge clk);
        #1 bus.req[p] = 1'b0;
        @(negedge clk);
        if (n < 4) bus.req[p] = 1'b1;
        else bus.req = 2'b00;
      end
    end
    repeat (3) @(negedge clk);
    vectors++; if (n != 4) begin miscompares++;
      $display("FAIL contend_timeout: got %0d bursts want 4", n); end
    vectors++; if (gseq_q.size() != 4) begin miscompares++;
      $display("FAIL contend_ngrants: got %0d want 4", gseq_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
        vectors++; if (gseq_q[i] !== eg) begin miscompares++;
          $display("FAIL contend_order%0d: got %b want %b", i, gseq_q[i], eg); end
      end
    end
    vectors++; if (twohot != 0) begin miscompares++;
      $display("FAIL contend_twohot: got %0d want 0", twohot); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [ADDR_W-1:0] ea[4];
    logic [7:0] ed[4];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ed = '{8'hC2, 8'hC3, 8'h3C, 8'h3D};
    clear_mon();
    do_burst(0, 16'hFFFE, 2'd3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got 0 want 1"); end
    vectors++; if (start_q.size() != 4 || rv_q.size() != 4) begin miscompares++;
      $display("FAIL wrap_count: got %0d/%0d want 4/4", start_q.size(), rv_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vectors++; if (start_q[i] !== ea[i] || rv_q[i] !== ed[i]) begin miscompares++;
          $display("FAIL wrap%0d: got %h/%h want %h/%h", i, start_q[i], rv_q[i], ea[i],
                   ed[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    clear_mon();
    @(negedge clk);
    bp_busy = 1'b1;
    bus.addr0 = 16'h0100; bus.len0 = 2'd0; bus.req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (bus.spi_start !== 1'b0 || bus.gnt !== 2'b01) begin miscompares++;
        $display("FAIL bp_hold%0d: got start=%b gnt=%b want 0/01", i, bus.spi_start,
                 bus.gnt); end
    end
    bp_busy = 1'b0;
    @(negedge clk);
    vectors++; if (bus.spi_start !== 1'b1 || bus.spi_addr !== 16'h0100) begin miscompares++;
      $display("FAIL bp_start: got %b/%h want 1/0100", bus.spi_start, bus.spi_addr); end
    @(negedge clk);
    vectors++; if (bus.spi_start !== 1'b0) begin miscompares++;
      $display("FAIL bp_single_pulse: got %b want 0", bus.spi_start); end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.rlast;
    end
    vectors++; if (got !== 1'b1 || bus.rdata !== 8'h3C) begin miscompares++;
      $display("FAIL bp_data: got rlast=%b rdata=%h want 1/3c", got, bus.rdata); end
    @(posedge clk);
    #1 bus.req[0] = 1'b0;
    @(negedge clk);
    vectors++; if (start_q.size() != 1 || start_busy != 0) begin miscompares++;
      $display("FAIL bp_nstart: got %0d starts, %0d while busy want 1/0", start_q.size(),
               start_busy); end
  endtask

  task automatic test_reset_midburst();
    bit got;
    clear_mon();
    bus.addr0 = 16'h0200; bus.len0 = 2'd3; bus.req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.spi_start;
    end
    vectors++; if (got !== 1'b1) begin miscompares++;
      $display("FAIL mid_no_start: got 0 want 1"); end
    reset = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    vectors++; if (bus.gnt !== 2'b00 || bus.rvalid !== 2'b00 || bus.rlast !== 1'b0 ||
                   bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL mid_reset_ctl: got gnt=%b rvalid=%b rlast=%b busy=%b want all 0",
               bus.gnt, bus.rvalid, bus.rlast, bus.busy); end
    vectors++; if (bus.rdata !== 8'h00 || bus.spi_start !== 1'b0 ||
                   bus.spi_addr !== 16'h0000) begin miscompares++;
      $display("FAIL mid_reset_data: got rdata=%h start=%b addr=%h want 00/0/0000",
               bus.rdata, bus.spi_start, bus.spi_addr); end
    reset = 1'b0;
    clear_mon();
    stray_data = 8'hEE;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    vectors++; if (rv_q.size() != 0 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL mid_stray: got %0d bytes busy=%b want 0/0", rv_q.size(), bus.busy); end
    bus.addr1 = 16'h0305; bus.len1 = 2'd0; bus.req[1] = 1'b1;
    @(negedge clk);
    vectors++; if (bus.gnt !== 2'b10) begin miscompares++;
      $display("FAIL mid_regrant: got %b want 10", bus.gnt); end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.rlast;
    end
    vectors++; if (got !== 1'b1 || bus.rvalid !== 2'b10 || bus.rdata !== 8'h39) begin
      miscompares++; $display("FAIL mid_new_data: got rlast=%b rvalid=%b rdata=%h want 1/10/39",
                              got, bus.rvalid, bus.rdata); end
    @(posedge clk);
    #1 bus.req[1] = 1'b0;
    @(negedge clk);
    vectors++; if (start_q.size() != 1 || (start_q.size() == 1 && start_q[0] !== 16'h0305))
    begin miscompares++;
      $display("FAIL mid_new_addr: got %0d starts want 1 at 0305", start_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_contention();
    test_wrap();
    test_backpressure();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want summary before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
